// File: rtl/sine_meter_pkg.sv
// Shared types and sizing for the sine frequency meter.
package sine_meter_pkg;

  typedef enum logic {IDLE, MEASURE} state_e;

  // Window counter width for the default TIMEOUT of 2^24 samples.
  localparam int CNT_W     = 25;
  // One quotient bit per iteration, 32-bit phase increment.
  localparam int DIV_ITERS = 32;

  // Numerator width for PERIODS * 2^32, plus a guard bit.
  function automatic int num_w(input int periods);
    return 32 + $clog2(periods) + 1;
  endfunction

  localparam int NUM_W = num_w(16);

endpackage

// File: rtl/serial_divider.sv
// Restoring serial divider: 32-bit saturating quotient, one bit per clock.
module serial_divider
  import sine_meter_pkg::*;
#(
  parameter int NUM_W = sine_meter_pkg::NUM_W,
  parameter int DEN_W = CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [NUM_W-1:0] i_num,
  input  logic [DEN_W-1:0] i_den,
  output logic             o_ready,
  output logic             o_finish,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_quot
);

  localparam int IW = $clog2(DIV_ITERS + 1);

  logic             busy_q;
  logic [IW-1:0]    iter_q;
  logic [DEN_W:0]   rem_q;
  logic [DEN_W-1:0] den_q;
  logic [31:0]      lo_q;
  logic [31:0]      quo_q;
  logic [31:0]      res_q;
  logic             sat_q;
  logic             done_q;

  logic [DEN_W:0]   rem_sh;
  logic             fit;
  logic             finish;

  // Partial remainder shifted by one numerator bit, and whether the divisor fits.
  always_comb begin
    rem_sh = {rem_q[DEN_W-1:0], lo_q[31]};
    fit    = rem_sh >= {1'b0, den_q};
  end

  // The result lands on the same edge a new division may be loaded.
  assign finish   = busy_q && (iter_q == IW'(DIV_ITERS));
  assign o_ready  = !busy_q || finish;
  assign o_finish = finish;
  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_quot   = res_q;

  // Load on start, iterate 32 times, then publish the quotient for one pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q <= 1'b0;
      iter_q <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      lo_q   <= '0;
      quo_q  <= '0;
      res_q  <= '0;
      sat_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy_q && !finish) begin
        rem_q  <= fit ? (rem_sh - {1'b0, den_q}) : rem_sh;
        lo_q   <= {lo_q[30:0], 1'b0};
        quo_q  <= {quo_q[30:0], fit};
        iter_q <= iter_q + IW'(1);
      end
      if (finish) begin
        res_q  <= sat_q ? '1 : quo_q;
        done_q <= 1'b1;
        busy_q <= 1'b0;
      end
      if (i_start && o_ready) begin
        busy_q <= 1'b1;
        iter_q <= '0;
        den_q  <= i_den;
        // Quotient needs more than 32 bits when den*2^32 <= num.
        sat_q  <= (i_num >> 32) >= NUM_W'(i_den);
        rem_q  <= (DEN_W + 1)'(i_num >> 32);
        lo_q   <= i_num[31:0];
        quo_q  <= '0;
      end
    end
  end

endmodule

// File: rtl/sine_freq_meter.sv
// Measures a sine tone's frequency over PERIODS cycles as a generator phase increment.
module sine_freq_meter
  import sine_meter_pkg::*;
#(
  parameter int PERIODS = 16,
  parameter int HYST    = 256,
  parameter int TIMEOUT = 16777216
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic signed [15:0] i_sample,
  input  logic               i_valid,
  output logic [31:0]        o_phase_adder,
  output logic               o_valid,
  output logic               o_locked,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_overrun
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int NW = num_w(PERIODS);
  localparam int PW = $clog2(PERIODS);
  localparam logic [NW-1:0] NUM = NW'(64'(PERIODS) << 32);

  state_e        state_q;
  logic          armed_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] pcnt_q;
  logic          locked_q;
  logic          timeout_q;
  logic          overrun_q;

  logic arm_lvl;
  logic xing;
  logic close;
  logic div_ready;
  logic div_finish;
  logic div_start;

  // Hysteresis: a crossing only counts once the signal has gone well negative.
  always_comb begin
    arm_lvl   = int'(i_sample) <= -HYST;
    xing      = armed_q && !i_sample[15];
    close     = i_valid && (state_q == MEASURE) && xing && (pcnt_q == PW'(PERIODS - 1));
    div_start = close && div_ready;
  end

  serial_divider #(
    .NUM_W (NW),
    .DEN_W (CW)
  ) u_div (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (div_start),
    .i_num    (NUM),
    .i_den    (cnt_q),
    .o_ready  (div_ready),
    .o_finish (div_finish),
    .o_busy   (o_busy),
    .o_done   (o_valid),
    .o_quot   (o_phase_adder)
  );

  // Detector, window counters and IDLE/MEASURE control, stepping on valid samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      if (div_finish) locked_q <= 1'b1;
      if (i_valid) begin
        if (arm_lvl) armed_q <= 1'b1;
        case (state_q)
          IDLE: begin
            if (xing) begin
              state_q <= MEASURE;
              armed_q <= 1'b0;
              cnt_q   <= CW'(1);
              pcnt_q  <= '0;
            end
          end
          MEASURE: begin
            if (close) begin
              // Closing crossing also opens the next window; a busy divider drops L.
              armed_q   <= 1'b0;
              cnt_q     <= CW'(1);
              pcnt_q    <= '0;
              overrun_q <= !div_ready;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
              state_q   <= IDLE;
              armed_q   <= 1'b0;
              cnt_q     <= '0;
              pcnt_q    <= '0;
              locked_q  <= 1'b0;
              timeout_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
              if (xing) begin
                armed_q <= 1'b0;
                pcnt_q  <= pcnt_q + PW'(1);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_locked  = locked_q;
  assign o_timeout = timeout_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_sine_freq_meter.sv
// Bench for sine_freq_meter: table of tone scenarios plus timeout and reset sequences.
module tb_sine_freq_meter;

  localparam int PERIODS = 16;
  localparam int HYST    = 256;
  localparam int TIMEOUT = 8192;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] sample = '0;
  logic               valid  = 1'b0;
  logic [31:0]        phase_adder;
  logic               res_v, locked, busy, tmo, ovr;

  sine_freq_meter #(.PERIODS(PERIODS), .HYST(HYST), .TIMEOUT(TIMEOUT)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_sample      (sample),
    .i_valid       (valid),
    .o_phase_adder (phase_adder),
    .o_valid       (res_v),
    .o_locked      (locked),
    .o_busy        (busy),
    .o_timeout     (tmo),
    .o_overrun     (ovr)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks valid-sample indices of crossings; a window spans PERIODS crossings
  // and its length is the index difference. Results are predicted as
  // (edge, value) pairs; the divider is a 33-edge resource.
  typedef struct { int e; logic [31:0] v; } res_t;
  res_t expq[$];
  bit   m_armed, m_meas, m_locked;
  int   m_open, m_nx, m_vidx, m_free, m_to, m_ov;
  int   n_res, n_tmo, n_ovr;

  function automatic logic [31:0] ref_q(input int len);
    logic [63:0] q;
    q = (64'(PERIODS) << 32) / 64'(len);
    return (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
  endfunction

  task automatic model_reset();
    expq.delete();
    m_armed = 0; m_meas = 0; m_locked = 0;
    m_open = 0; m_nx = 0; m_free = 0; m_to = -1; m_ov = -1;
  endtask

  task automatic model(input logic signed [15:0] s, input logic v, input int e);
    bit x;
    if (!v) return;
    if (int'(s) <= -HYST) m_armed = 1;
    x = m_armed && (s >= 0);
    if (!m_meas) begin
      if (x) begin m_meas = 1; m_open = m_vidx; m_nx = 0; m_armed = 0; end
    end else if (x && m_nx == PERIODS - 1) begin
      if (e >= m_free) begin
        expq.push_back('{e + 33, ref_q(m_vidx - m_open)});
        m_free = e + 33;
      end else m_ov = e;
      m_open = m_vidx; m_nx = 0; m_armed = 0;
    end else if (m_vidx - m_open + 1 == TIMEOUT) begin
      m_to = e; m_meas = 0; m_armed = 0;
    end else if (x) begin
      m_nx++; m_armed = 0;
    end
    m_vidx++;
  endtask

  task automatic check_outputs();
    bit ev;
    logic [4:0] expv;
    ev = (expq.size() > 0) && (expq[0].e == edge_n);
    if (ev) m_locked = 1;
    if (m_to == edge_n) m_locked = 0;
    expv = {ev, m_to == edge_n, m_ov == edge_n, m_locked,
            (edge_n >= m_free - 33) && (edge_n < m_free)};
    chk("flags{valid,timeout,overrun,locked,busy}", {res_v, tmo, ovr, locked, busy}, expv);
    if (res_v) n_res++;
    if (tmo) n_tmo++;
    if (ovr) n_ovr++;
    if (ev) begin
      chk("phase_adder", phase_adder, expq[0].v);
      void'(expq.pop_front());
    end
    while (expq.size() > 0 && expq[0].e < edge_n) void'(expq.pop_front());
  endtask

  task automatic step(input logic signed [15:0] s, input logic v);
    @(negedge clk);
    check_outputs();
    model(s, v, edge_n + 1);
    sample = s;
    valid  = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; valid = 0; sample = '0;
    #1;
    chk("reset outputs", {phase_adder, res_v, locked, busy, tmo, ovr}, 64'd0);
    model_reset();
    n_res = 0; n_tmo = 0; n_ovr = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  // ---------------- stimulus ----------------
  // kind 0: sine amp 20000 with phase increment pinc (half-step offset), optional +-100 noise
  // kind 1: square +-1000, 100-sample period
  // kind 2: period-2 toggle of amplitude pinc
  // vmod 1: always valid, 2: every other cycle, 0: random 3/4
  typedef struct {
    int kind; logic [31:0] pinc; int vmod; bit noise; int ncyc;
    logic [31:0] expv; int min_res; bit exp_lock; bit exp_ovr;
  } row_t;

  function automatic logic signed [15:0] gen(input row_t r, input int vi);
    logic [31:0] ph;
    real a;
    int s;
    s = 0;
    case (r.kind)
      0: begin
        ph = r.pinc / 2 + r.pinc * 32'(vi);
        a  = real'(ph) / 4294967296.0 * 6.283185307179586;
        s  = int'(20000.0 * $sin(a));
        if (r.noise) s = s + int'($urandom_range(200)) - 100;
      end
      1: s = (vi % 100 < 50) ? -1000 : 1000;
      default: s = (vi % 2 == 1) ? int'(r.pinc) : -int'(r.pinc);
    endcase
    return 16'(s);
  endfunction

  task automatic run_row(input row_t r, input int ncyc);
    int  vi;
    bit  v;
    vi = 0;
    for (int c = 0; c < ncyc; c++) begin
      case (r.vmod)
        1:       v = 1;
        2:       v = (c % 2 == 0);
        default: v = ($urandom_range(3) != 0);
      endcase
      if (v) begin
        step(gen(r, vi), 1'b1);
        vi++;
      end else step(16'($urandom), 1'b0);
    end
  endtask

  row_t rows[8];

  initial begin
    rows[0] = '{0, 32'h0400_0000, 1, 0, 4000,  32'h0400_0000, 2, 1, 0};
    rows[1] = '{0, 32'h0100_0000, 2, 0, 10000, 32'h0100_0000, 1, 1, 0};
    rows[2] = '{1, 32'd0,         1, 0, 3500,  32'h028F_5C28, 2, 1, 0};
    rows[3] = '{1, 32'd0,         0, 0, 5000,  32'h028F_5C28, 1, 1, 0};
    rows[4] = '{0, 32'h0400_0000, 1, 1, 4000,  32'h0400_0000, 2, 1, 0};
    rows[5] = '{2, 32'd0,         1, 0, 500,   32'h0,         0, 0, 0};
    rows[6] = '{2, 32'd200,       1, 0, 500,   32'h0,         0, 0, 0};
    rows[7] = '{2, 32'd300,       1, 0, 400,   32'h8000_0000, 1, 1, 1};
    m_vidx = 0;
    model_reset();

    for (int i = 0; i < 8; i++) begin
      do_reset();
      run_row(rows[i], rows[i].ncyc);
      if (rows[i].min_res == 0)
        chk($sformatf("row%0d result count", i), 64'(n_res), 64'd0);
      else begin
        chk($sformatf("row%0d enough results", i), 64'(n_res >= rows[i].min_res), 64'd1);
        chk($sformatf("row%0d final phase_adder", i), 64'(phase_adder), 64'(rows[i].expv));
      end
      chk($sformatf("row%0d locked", i), 64'(locked), 64'(rows[i].exp_lock));
      chk($sformatf("row%0d overrun seen", i), 64'(n_ovr > 0), 64'(rows[i].exp_ovr));
    end

    // Lock on a 64-sample tone, then freeze the input: window must time out.
    do_reset();
    run_row(rows[0], 2500);
    chk("pre-timeout locked", 64'(locked), 64'd1);
    for (int c = 0; c < 8300; c++) step(16'sd5000, 1'b1);
    chk("timeout pulses", 64'(n_tmo), 64'd1);
    chk("locked after timeout", 64'(locked), 64'd0);
    chk("phase_adder held", 64'(phase_adder), 64'h0400_0000);

    // Reset while the first division is in flight: no stale result afterwards.
    do_reset();
    run_row(rows[2], 1660);
    chk("busy mid-division", 64'(busy), 64'd1);
    do_reset();
    for (int c = 0; c < 60; c++) step(16'sd0, 1'b0);
    chk("no result after reset", 64'(n_res), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
